// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths, FSM state encodings and beat index type for the cache-line adaptor.
// Optional build macro used by the top: CACHELINE_ADAPTOR_ALIGN_EN.
package cacheline_adaptor_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = $clog2(LINE_W / 8);

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

endpackage

// File: rtl/cacheline_beat_buffer.sv
// Line storage for the adaptor: a read line assembled one beat at a time and a
// latched write line served back out one beat at a time.
module cacheline_beat_buffer
  import cacheline_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_line,
  input  logic [LINE_W-1:0] line_in,
  input  logic              beat_we,
  input  beat_idx_t         beat_idx,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [LINE_W-1:0] rd_line,
  output logic [BEAT_W-1:0] beat_out
);

  logic [LINE_W-1:0] rd_line_q;
  logic [LINE_W-1:0] wr_line_q;

  // Separate registers so a write transaction never disturbs the last read line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_line_q <= '0;
      wr_line_q <= '0;
    end else begin
      if (load_line)
        wr_line_q <= line_in;
      if (beat_we)
        rd_line_q[beat_idx*BEAT_W +: BEAT_W] <= beat_in;
    end
  end

  assign rd_line  = rd_line_q;
  assign beat_out = wr_line_q[beat_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit line requests into 4-beat 64-bit memory bursts and back.
// Define CACHELINE_ADAPTOR_ALIGN_EN to force the latched address to 32-byte alignment.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  output logic [ADDR_W-1:0] burst_addr
);

  state_t            state;
  beat_idx_t         cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_in;
  logic [BEAT_W-1:0] beat_sel;
  logic              load_line;
  logic              beat_we;

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
  assign addr_in = {line_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
`else
  assign addr_in = line_addr;
`endif

  assign load_line = (state == IDLE) && line_write;
  assign beat_we   = (state == READ) && burst_resp;

  // Write wins when both requests arrive together; memory strobes count only mid-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_write) begin
            addr_q <= addr_in;
            cnt    <= '0;
            state  <= WRITE;
          end else if (line_read) begin
            addr_q <= addr_in;
            cnt    <= '0;
            state  <= READ;
          end
        end
        READ, WRITE: begin
          if (burst_resp) begin
            cnt <= cnt + beat_idx_t'(1);
            if (cnt == LAST_BEAT)
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  cacheline_beat_buffer u_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_line (load_line),
    .line_in   (line_wdata),
    .beat_we   (beat_we),
    .beat_idx  (cnt),
    .beat_in   (burst_rdata),
    .rd_line   (line_rdata),
    .beat_out  (beat_sel)
  );

  assign burst_read  = (state == READ);
  assign burst_write = (state == WRITE);
  assign line_resp   = (state == DONE);
  assign burst_wdata = (state == WRITE) ? beat_sel : '0;
  assign burst_addr  = ((state == READ) || (state == WRITE)) ? addr_q : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor with a small burst-memory responder.
// Honours CACHELINE_ADAPTOR_ALIGN_EN when computing expected burst addresses.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              line_read;
  logic              line_write;
  logic [ADDR_W-1:0] line_addr;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_resp;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;
  logic              burst_read;
  logic              burst_write;
  logic [BEAT_W-1:0] burst_wdata;
  logic [ADDR_W-1:0] burst_addr;

  int checks   = 0;
  int failures = 0;

  localparam logic [LINE_W-1:0] RD_LINE_A = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [LINE_W-1:0] WR_LINE   = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
  localparam logic [LINE_W-1:0] RD_LINE_B = {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}};
  localparam logic [LINE_W-1:0] RD_LINE_C = {{16{4'hF}}, {16{4'hE}}, {16{4'h0}}, {16{4'h9}}};

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk         (clk),
    .rst         (rst),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_addr   (line_addr),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_wdata (burst_wdata),
    .burst_addr  (burst_addr)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_burst_addr(input logic [ADDR_W-1:0] a);
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    return {a[ADDR_W-1:5], 5'b0};
`else
    return a;
`endif
  endfunction

  // Issues one line request at a negedge and plays the memory side until line_resp.
  // Returns at the negedge of the IDLE cycle that follows DONE.
  task automatic run_txn(input string name, input logic is_write, input logic also_read,
                         input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                         input int gap_beat, input int gap_len,
                         input logic [LINE_W-1:0] exp_rdata, input int exp_lat);
    int   cyc, bidx, gaps, rd_cyc, wr_cyc;
    logic done;
    logic [3:0][BEAT_W-1:0] beats;
    beats      = line;
    cyc        = 0;
    bidx       = 0;
    gaps       = 0;
    rd_cyc     = 0;
    wr_cyc     = 0;
    done       = 1'b0;
    line_write = is_write;
    line_read  = !is_write || also_read;
    line_addr  = addr;
    line_wdata = is_write ? line : ~line;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      burst_resp = 1'b0;
      if (line_resp) begin
        done = 1'b1;
      end else begin
        if (burst_read)  rd_cyc++;
        if (burst_write) wr_cyc++;
        if ((burst_read || burst_write) && bidx < 4) begin
          if (bidx == gap_beat && gaps < gap_len) begin
            gaps++;
          end else begin
            check({name, "_addr"}, LINE_W'(burst_addr), LINE_W'(exp_burst_addr(addr)));
            if (is_write)
              check({name, "_wdata"}, LINE_W'(burst_wdata), LINE_W'(beats[bidx]));
            burst_rdata = is_write ? ~beats[bidx] : beats[bidx];
            burst_resp  = 1'b1;
            bidx++;
          end
        end
      end
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    burst_resp = 1'b0;
    check({name, "_done"}, LINE_W'(done), LINE_W'(1'b1));
    check({name, "_latency"}, LINE_W'(cyc), LINE_W'(exp_lat));
    check({name, "_read_cycles"}, LINE_W'(rd_cyc), LINE_W'(is_write ? 0 : 4 + gap_len));
    check({name, "_write_cycles"}, LINE_W'(wr_cyc), LINE_W'(is_write ? 4 + gap_len : 0));
    check({name, "_rdata_done"}, line_rdata, exp_rdata);
    @(negedge clk);
    check({name, "_resp_pulse"}, LINE_W'(line_resp), '0);
    check({name, "_req_idle"}, LINE_W'({burst_read, burst_write}), '0);
    check({name, "_addr_idle"}, LINE_W'(burst_addr), '0);
    check({name, "_wdata_idle"}, LINE_W'(burst_wdata), '0);
    check({name, "_rdata_idle"}, line_rdata, exp_rdata);
  endtask

  initial begin
    rst         = 1'b1;
    line_read   = 1'b0;
    line_write  = 1'b0;
    line_addr   = '0;
    line_wdata  = '0;
    burst_rdata = '0;
    burst_resp  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_line_resp", LINE_W'(line_resp), '0);
    check("reset_burst_req", LINE_W'({burst_read, burst_write}), '0);
    check("reset_burst_wdata", LINE_W'(burst_wdata), '0);
    check("reset_burst_addr", LINE_W'(burst_addr), '0);
    check("reset_line_rdata", line_rdata, '0);
    rst = 1'b0;

    // Memory strobe while idle must not touch the read line.
    burst_rdata = {16{4'hE}};
    burst_resp  = 1'b1;
    @(negedge clk);
    burst_resp = 1'b0;
    @(negedge clk);
    check("idle_resp_rdata", line_rdata, '0);
    check("idle_resp_req", LINE_W'({burst_read, burst_write, line_resp}), '0);

    run_txn("read_a", 1'b0, 1'b0, 32'h0000_1040, RD_LINE_A, -1, 0, RD_LINE_A, 5);
    run_txn("write", 1'b1, 1'b0, 32'h0000_2000, WR_LINE, -1, 0, RD_LINE_A, 5);
    run_txn("read_gap", 1'b0, 1'b0, 32'h0000_3000, RD_LINE_B, 2, 2, RD_LINE_B, 7);
    run_txn("both_req", 1'b1, 1'b1, 32'h0000_4000, WR_LINE, -1, 0, RD_LINE_B, 5);

    // Reset in the middle of a read after three beats have landed.
    line_read = 1'b1;
    line_addr = 32'h0000_0080;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      burst_rdata = {16{4'h3 + 4'(i)}};
      burst_resp  = 1'b1;
      @(negedge clk);
    end
    burst_resp = 1'b0;
    check("midrst_pre_read", LINE_W'(burst_read), LINE_W'(1'b1));
    rst       = 1'b1;
    line_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_burst_read", LINE_W'(burst_read), '0);
    check("midrst_line_resp", LINE_W'(line_resp), '0);
    check("midrst_line_rdata", line_rdata, '0);
    check("midrst_burst_addr", LINE_W'(burst_addr), '0);

    run_txn("read_after_rst", 1'b0, 1'b0, 32'h0000_0040, RD_LINE_C, -1, 0, RD_LINE_C, 5);
    run_txn("read_unaligned", 1'b0, 1'b0, 32'h0000_1047, RD_LINE_A, -1, 0, RD_LINE_A, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts single-cycle 256-bit cache-line requests from the cache arbiter into 4-beat, 64-bit bursts on the physical-memory port, and reassembles read bursts into a full line. Sits directly downstream of the cache arbiter: its line-side port is the arbiter's memory port, and its burst side drives physical memory. One transaction at a time; no queuing.

## Interface
- LINE_W, 256, cache line width in bits
- BEAT_W, 64, burst beat width in bits; BEATS = LINE_W/BEAT_W = 4
- ADDR_W, 32, address width
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- line_read  in  1  line read request from arbiter, held until line_resp
- line_write  in  1  line write request from arbiter, held until line_resp
- line_addr  in  ADDR_W  line address
- line_wdata  in  LINE_W  write line
- line_rdata  out  LINE_W  assembled read line
- line_resp  out  1  one-cycle completion pulse
- burst_rdata  in  BEAT_W  read beat from memory
- burst_resp  in  1  memory beat strobe (one beat per high cycle)
- burst_read  out  1  burst read request
- burst_write  out  1  burst write request
- burst_wdata  out  BEAT_W  current write beat
- burst_addr  out  ADDR_W  burst address

## Operation
- States: IDLE, READ, WRITE, DONE. 2-bit beat counter cnt.
- IDLE: line_write high -> latch addr and wdata, cnt=0, go WRITE; else line_read high -> latch addr, cnt=0, go READ. Both high: write wins.
- READ: burst_read=1. Each burst_resp cycle stores burst_rdata into line_rdata[cnt*64 +: 64], cnt++. Beat on cnt==3 -> DONE.
- WRITE: burst_write=1, burst_wdata = latched line[cnt*64 +: 64]. Each burst_resp cycle advances cnt; beat on cnt==3 -> DONE.
- DONE: line_resp=1 for exactly one cycle, line_rdata stable; unconditional -> IDLE.
- burst_resp gaps between beats allowed; request stays asserted, cnt holds.
- burst_resp in IDLE or DONE ignored; line inputs ignored outside IDLE (latched copies used).
- burst_addr = latched address during READ/WRITE, 0 otherwise.
- line_rdata retains last completed read until next read beat 0 overwrites it; a write does not alter it.

## Timing
- Reset values: line_resp 0, burst_read 0, burst_write 0, burst_wdata 0, burst_addr 0, line_rdata 0, state IDLE, cnt 0.
- Request sampled at edge in IDLE; burst_read/burst_write high the next cycle.
- With back-to-back beats: request at cycle t -> beats t+1..t+4 -> line_resp at t+5. Minimum latency 5 cycles; each idle memory cycle adds one.
- Back-to-back transactions: one IDLE cycle after DONE before next acceptance; arbiter deasserts/switches requests during that cycle.
- rst mid-burst: all outputs to reset values next cycle, burst abandoned; memory side must also be reset.

## Configuration
- CACHELINE_ADAPTOR_ALIGN_EN defined: latched address low log2(LINE_W/8)=5 bits forced to 0, burst_addr always 32-byte aligned.
- Undefined: line_addr passed through unmodified.

## Structure
- Package cacheline_adaptor_pkg: state enum (IDLE, READ, WRITE, DONE), LINE_W/BEAT_W/BEATS constants, beat index type.
- One sub-module natural: cacheline_beat_buffer, the 256-bit line register with beat-indexed write (read assembly) and beat-indexed select (write disassembly); FSM and counter stay in top.

## Test plan
- Read 0x0000_1040, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> burst_read high 4 cycles, line_resp at t+5, line_rdata = {0x44..,0x33..,0x22..,0x11..}.
- Write 0x0000_2000, line_wdata = {0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA..} -> burst_wdata 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. on successive burst_resp; line_resp once.
- Read with 2-cycle gap between beats 1 and 2 -> cnt holds, burst_read held, line_resp at t+7, data correct.
- line_read and line_write both high in IDLE -> WRITE taken, burst_read never asserted.
- rst after beat 2 of read -> next cycle burst_read 0, line_resp 0, line_rdata 0; following read 0x40 completes normally.
- Read 0x0000_1047 -> burst_addr 0x0000_1040 with CACHELINE_ADAPTOR_ALIGN_EN, 0x0000_1047 without.
